// File: rtl/udm_pkg.sv
// Shared types and constants for the sequential UDM multiplier.
// Used by udm_digit_mult (UDM_SEQ_EXACT_EN selects exact digits) and udm_seq_mult_ctrl.
package udm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } udm_state_e;

    localparam int UDM_DIGIT_W = 2;
    localparam int UDM_PP_W    = 4;

endpackage

// File: rtl/udm_digit_mult.sv
// Combinational 2x2 digit product; approximate UDM rule by default,
// exact product when UDM_SEQ_EXACT_EN is defined.
module udm_digit_mult
    import udm_pkg::*;
(
    input  logic [UDM_DIGIT_W-1:0] a,
    input  logic [UDM_DIGIT_W-1:0] b,
    output logic [UDM_PP_W-1:0]    z
);

`ifdef UDM_SEQ_EXACT_EN
    assign z = UDM_PP_W'(a) * UDM_PP_W'(b);
`else
    // 3x3 collapses to 7; every other pair is exact
    assign z = {1'b0,
                a[1] & b[1],
                (a[1] & b[0]) | (a[0] & b[1]),
                a[0] & b[0]};
`endif

endmodule

// File: rtl/udm_seq_mult_ctrl.sv
// Sequencer building an OP_WIDTH x OP_WIDTH product from one shared 2x2 digit multiplier.
// Digit arithmetic is exact when UDM_SEQ_EXACT_EN is defined, UDM-approximate otherwise.
module udm_seq_mult_ctrl
    import udm_pkg::*;
#(
    parameter int OP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   in_a,
    input  logic [OP_WIDTH-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*OP_WIDTH-1:0] out_prod,
    output logic                  busy
);

    localparam int ND = OP_WIDTH / UDM_DIGIT_W;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam int PW = 2 * OP_WIDTH;
    localparam logic [IW-1:0] IDX_LAST = IW'(ND - 1);

    udm_state_e            state;
    logic [OP_WIDTH-1:0]   a_q;
    logic [OP_WIDTH-1:0]   b_q;
    logic [PW-1:0]         acc;
    logic [IW-1:0]         i;
    logic [IW-1:0]         j;

    logic [UDM_DIGIT_W-1:0] a_dig;
    logic [UDM_DIGIT_W-1:0] b_dig;
    logic [UDM_PP_W-1:0]    pp;
    logic [PW-1:0]          pp_ext;
    logic [PW-1:0]          term;

    assign a_dig  = a_q[i*UDM_DIGIT_W +: UDM_DIGIT_W];
    assign b_dig  = b_q[j*UDM_DIGIT_W +: UDM_DIGIT_W];
    assign pp_ext = {{(PW-UDM_PP_W){1'b0}}, pp};
    assign term   = pp_ext << (UDM_DIGIT_W * (int'(i) + int'(j)));

    udm_digit_mult u_dmul (
        .a (a_dig),
        .b (b_dig),
        .z (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_prod  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc + term;
                    if (j == IDX_LAST) begin
                        j <= '0;
                        if (i == IDX_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Publish the sum one cycle after the last pair lands
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_prod  <= acc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
